// File: rtl/cdp_sqsum_pkg.sv
// Shared helpers for the CDP square-sum window pipe.
//   clog2     : ceiling log2 for elaboration-time widths
//   full_bw   : full-precision width of a MAX_TAPS-tap sum of IN_BW-bit values
//   centre    : index of the centre tap (also the number of symmetric tap pairs)
//   sat_u     : unsigned clamp of a value to out_bw bits
package cdp_sqsum_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned full_bw(input int unsigned in_bw, input int unsigned max_taps);
    return in_bw + clog2(max_taps);
  endfunction

  function automatic int unsigned centre(input int unsigned max_taps);
    return (max_taps - 1) / 2;
  endfunction

  function automatic logic [63:0] sat_u(input logic [63:0] v, input int unsigned out_bw);
    logic [63:0] m;
    if (out_bw >= 64) return v;
    m = (64'd1 << out_bw) - 64'd1;
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/cdp_sqsum_window_pipe_if.sv
// Handshake bundle for the square-sum window pipe.
//   sq_valid/sq_ready/sq_pd/cfg_half_len : input beat (taps + per-beat half window)
//   sum_valid/sum_ready/sum_pd/sum_sat   : output beat (window sum + clamp flag)
// master: upstream/downstream driver side; slave: the pipe itself.
interface cdp_sqsum_window_pipe_if #(
  parameter int unsigned IN_BW    = 17,
  parameter int unsigned MAX_TAPS = 9,
  parameter int unsigned HLEN_BW  = 3,
  parameter int unsigned OUT_BW   = 21
);
  logic                      sq_valid;
  logic                      sq_ready;
  logic [MAX_TAPS*IN_BW-1:0] sq_pd;
  logic [HLEN_BW-1:0]        cfg_half_len;
  logic                      sum_valid;
  logic                      sum_ready;
  logic [OUT_BW-1:0]         sum_pd;
  logic                      sum_sat;

  modport master (
    output sq_valid, sq_pd, cfg_half_len, sum_ready,
    input  sq_ready, sum_valid, sum_pd, sum_sat
  );

  modport slave (
    input  sq_valid, sq_pd, cfg_half_len, sum_ready,
    output sq_ready, sum_valid, sum_pd, sum_sat
  );
endinterface

// File: rtl/cdp_sqsum_pair_stage.sv
// S1 of the square-sum pipe: clamps the half window, folds the taps into
// centre + symmetric pair sums, masks pairs outside the window, registers them.
//   i_clk/i_rst   : clock, synchronous active-high reset
//   i_valid/o_adv : input beat valid / stage can accept (drives sq_ready)
//   i_pd          : taps, tap i at [i*IN_BW +: IN_BW]
//   i_half_len    : half window for this beat
//   i_s2_adv      : downstream stage advancing this cycle
//   o_valid       : S1 holds a beat
//   o_centre      : registered centre tap
//   o_pairs       : registered pair sums, pair k (1-based) at [(k-1)*(IN_BW+1) +: IN_BW+1]
module cdp_sqsum_pair_stage
  import cdp_sqsum_pkg::*;
#(
  parameter int unsigned IN_BW    = 17,
  parameter int unsigned MAX_TAPS = 9,
  parameter int unsigned HLEN_BW  = 3
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_valid,
  input  logic [MAX_TAPS*IN_BW-1:0]                     i_pd,
  input  logic [HLEN_BW-1:0]                            i_half_len,
  input  logic                                          i_s2_adv,
  output logic                                          o_adv,
  output logic                                          o_valid,
  output logic [IN_BW-1:0]                              o_centre,
  output logic [centre(MAX_TAPS)*(IN_BW+1)-1:0]         o_pairs
);
  localparam int unsigned C  = centre(MAX_TAPS);
  localparam int unsigned PW = IN_BW + 1;

  logic [IN_BW-1:0]   w_tap [MAX_TAPS];
  logic [HLEN_BW-1:0] w_hlen;
  logic [C*PW-1:0]    w_pairs;

  logic               r_valid;
  logic [IN_BW-1:0]   r_centre;
  logic [C*PW-1:0]    r_pairs;

  always_comb begin
    for (int unsigned i = 0; i < MAX_TAPS; i++) w_tap[i] = i_pd[i*IN_BW +: IN_BW];
  end

  assign w_hlen = (32'(i_half_len) > C) ? HLEN_BW'(C) : i_half_len;

  // Pairs beyond the window are zeroed here, so nothing from an earlier beat leaks in.
  always_comb begin
    w_pairs = '0;
    for (int unsigned k = 1; k <= C; k++) begin
      if (32'(w_hlen) >= k)
        w_pairs[(k-1)*PW +: PW] = PW'(w_tap[C-k]) + PW'(w_tap[C+k]);
    end
  end

  assign o_adv = !r_valid || i_s2_adv;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else begin
      if (o_adv) r_valid <= i_valid;
      if (o_adv && i_valid) begin
        r_centre <= w_tap[C];
        r_pairs  <= w_pairs;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_centre = r_centre;
  assign o_pairs  = r_pairs;
endmodule

// File: rtl/cdp_sqsum_window_pipe.sv
// Elastic two-stage sum of a centred window of squared taps.
//   nvdla_core_clk : clock
//   nvdla_core_rst : synchronous active-high reset
//   bus (slave)    : sq_* input beat with cfg_half_len, sum_* output beat with sum_sat
// S1 (pair stage) folds taps into pair sums; S2 reduces them, clamps to OUT_BW
// and holds the output until sum_ready.
module cdp_sqsum_window_pipe
  import cdp_sqsum_pkg::*;
#(
  parameter int unsigned IN_BW    = 17,
  parameter int unsigned MAX_TAPS = 9,
  parameter int unsigned HLEN_BW  = 3,
  parameter int unsigned OUT_BW   = 21
) (
  input logic                    nvdla_core_clk,
  input logic                    nvdla_core_rst,
  cdp_sqsum_window_pipe_if.slave bus
);
  localparam int unsigned NPAIR = centre(MAX_TAPS);
  localparam int unsigned PW    = IN_BW + 1;
  localparam int unsigned FBW   = full_bw(IN_BW, MAX_TAPS);

  logic                w_s1_valid;
  logic                w_s1_adv;
  logic                w_s2_adv;
  logic [IN_BW-1:0]    w_centre;
  logic [NPAIR*PW-1:0] w_pairs;
  logic [FBW-1:0]      w_total;
  logic [OUT_BW-1:0]   w_pd;
  logic                w_sat;

  logic                r_valid;
  logic [OUT_BW-1:0]   r_pd;
  logic                r_sat;

  assign w_s2_adv = !r_valid || bus.sum_ready;

  cdp_sqsum_pair_stage #(
    .IN_BW    (IN_BW),
    .MAX_TAPS (MAX_TAPS),
    .HLEN_BW  (HLEN_BW)
  ) u_s1 (
    .i_clk      (nvdla_core_clk),
    .i_rst      (nvdla_core_rst),
    .i_valid    (bus.sq_valid),
    .i_pd       (bus.sq_pd),
    .i_half_len (bus.cfg_half_len),
    .i_s2_adv   (w_s2_adv),
    .o_adv      (w_s1_adv),
    .o_valid    (w_s1_valid),
    .o_centre   (w_centre),
    .o_pairs    (w_pairs)
  );

  assign bus.sq_ready = w_s1_adv;

  always_comb begin
    w_total = FBW'(w_centre);
    for (int unsigned k = 0; k < NPAIR; k++) w_total = w_total + FBW'(w_pairs[k*PW +: PW]);
  end

  // When OUT_BW covers the full width the clamp is a no-op and sat stays 0.
  assign w_pd  = OUT_BW'(sat_u(64'(w_total), OUT_BW));
  assign w_sat = (sat_u(64'(w_total), OUT_BW) != 64'(w_total));

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_valid <= 1'b0;
      r_pd    <= '0;
      r_sat   <= 1'b0;
    end else if (w_s2_adv) begin
      r_valid <= w_s1_valid;
      if (w_s1_valid) begin
        r_pd  <= w_pd;
        r_sat <= w_sat;
      end
    end
  end

  assign bus.sum_valid = r_valid;
  assign bus.sum_pd    = r_pd;
  assign bus.sum_sat   = r_sat;
endmodule

// File: tb/tb_cdp_sqsum_window_pipe.sv
module tb_cdp_sqsum_window_pipe;
  localparam int unsigned IN_BW    = 17;
  localparam int unsigned MAX_TAPS = 9;
  localparam int unsigned HLEN_BW  = 3;
  localparam int unsigned OUT_A    = 21;
  localparam int unsigned OUT_B    = 18;
  localparam int unsigned PD_W     = IN_BW * MAX_TAPS;

  typedef logic [PD_W-1:0] pd_t;
  typedef struct packed {
    logic [20:0] pd;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out_a  = 0;
  int   n_out_b  = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  cdp_sqsum_window_pipe_if #(.IN_BW(IN_BW), .MAX_TAPS(MAX_TAPS), .HLEN_BW(HLEN_BW), .OUT_BW(OUT_A)) if_a ();
  cdp_sqsum_window_pipe_if #(.IN_BW(IN_BW), .MAX_TAPS(MAX_TAPS), .HLEN_BW(HLEN_BW), .OUT_BW(OUT_B)) if_b ();

  // Second instance sees identical stimulus; only its output width differs.
  assign if_b.sq_valid     = if_a.sq_valid;
  assign if_b.sq_pd        = if_a.sq_pd;
  assign if_b.cfg_half_len = if_a.cfg_half_len;
  assign if_b.sum_ready    = if_a.sum_ready;

  cdp_sqsum_window_pipe #(.IN_BW(IN_BW), .MAX_TAPS(MAX_TAPS), .HLEN_BW(HLEN_BW), .OUT_BW(OUT_A)) dut_a (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (if_a)
  );

  cdp_sqsum_window_pipe #(.IN_BW(IN_BW), .MAX_TAPS(MAX_TAPS), .HLEN_BW(HLEN_BW), .OUT_BW(OUT_B)) dut_b (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (if_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_sum(input pd_t pd, input logic [HLEN_BW-1:0] hl);
    int unsigned h;
    logic [63:0] s;
    h = (hl > 3'd4) ? 4 : 32'(hl);
    s = '0;
    for (int unsigned i = 4 - h; i <= 4 + h; i++) s = s + 64'(pd[i*IN_BW +: IN_BW]);
    return s;
  endfunction

  function automatic exp_t model(input logic [63:0] s, input int unsigned bw);
    logic [63:0] m;
    exp_t e;
    m = (64'd1 << bw) - 64'd1;
    e.pd  = 21'((s > m) ? m : s);
    e.sat = (s > m);
    return e;
  endfunction

  function automatic pd_t fill(input logic [IN_BW-1:0] v);
    pd_t p;
    for (int unsigned i = 0; i < MAX_TAPS; i++) p[i*IN_BW +: IN_BW] = v;
    return p;
  endfunction

  function automatic pd_t ramp();
    pd_t p;
    for (int unsigned i = 0; i < MAX_TAPS; i++) p[i*IN_BW +: IN_BW] = IN_BW'(i + 1);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input pd_t pd, input logic [HLEN_BW-1:0] hl);
    logic [63:0] s;
    bit ok;
    ok = 1'b0;
    s  = ref_sum(pd, hl);
    if_a.sq_valid     = 1'b1;
    if_a.sq_pd        = pd;
    if_a.cfg_half_len = hl;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (if_a.sq_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      q_a.push_back(model(s, OUT_A));
      q_b.push_back(model(s, OUT_B));
      step();
    end else begin
      check("send_timeout", 64'd0, 64'd1);
    end
    // Junk on the data lines while idle must be ignored.
    if_a.sq_valid     = 1'b0;
    if_a.sq_pd        = pd_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    if_a.cfg_half_len = HLEN_BW'($urandom());
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 60 && (q_a.size() != 0 || q_b.size() != 0); t++) @(negedge clk);
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if_a.sum_valid && if_a.sum_ready) begin
      n_out_a++;
      check("a_extra_beat", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_sum_pd", 64'(if_a.sum_pd), 64'(e.pd));
        check("a_sum_sat", 64'(if_a.sum_sat), 64'(e.sat));
      end
    end
    if (!rst && if_b.sum_valid && if_b.sum_ready) begin
      n_out_b++;
      check("b_extra_beat", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_sum_pd", 64'(if_b.sum_pd), 64'(e.pd));
        check("b_sum_sat", 64'(if_b.sum_sat), 64'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit seen;
    logic [HLEN_BW-1:0] hl_list [5];
    logic [HLEN_BW-1:0] cfg_list [3];

    if_a.sq_valid     = 1'b0;
    if_a.sq_pd        = '0;
    if_a.cfg_half_len = '0;
    if_a.sum_ready    = 1'b1;
    rst               = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sum_valid", 64'(if_a.sum_valid), 64'd0);
    check("rst_sum_pd", 64'(if_a.sum_pd), 64'd0);
    check("rst_sum_sat", 64'(if_a.sum_sat), 64'd0);
    check("rst_b_sum_valid", 64'(if_b.sum_valid), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sq_ready", 64'(if_a.sq_ready), 64'd1);
    check("post_rst_sum_valid", 64'(if_a.sum_valid), 64'd0);

    // Full window, latency of two edges
    step();
    send(fill(17'h10000), 3'd4);
    @(negedge clk);
    check("lat_n1_valid", 64'(if_a.sum_valid), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(if_a.sum_valid), 64'd1);
    check("lat_n2_pd", 64'(if_a.sum_pd), 64'h90000);
    check("lat_n2_sat", 64'(if_a.sum_sat), 64'd0);
    wait_drain();

    // Window length sweep including clamp of an over-range half length
    hl_list = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    step();
    foreach (hl_list[i]) send(ramp(), hl_list[i]);
    wait_drain();

    // Four back-to-back beats, beat 2 stalled for three cycles at the output
    step();
    n0 = n_out_a;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(fill(IN_BW'(k)), 3'd4);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
          step();
          if (if_a.sum_valid && if_a.sum_pd == 21'd18) seen = 1'b1;
        end
        check("stall_beat2_seen", 64'(seen), 64'd1);
        if_a.sum_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_valid", 64'(if_a.sum_valid), 64'd1);
          check("stall_pd", 64'(if_a.sum_pd), 64'd18);
          check("stall_sat", 64'(if_a.sum_sat), 64'd0);
          check("stall_sq_ready", 64'(if_a.sq_ready), 64'd0);
          step();
        end
        if_a.sum_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_beat_count", 64'(n_out_a - n0), 64'd4);

    // Saturation on the narrow instance, then a small sum
    step();
    send(fill(17'h1FFFF), 3'd4);
    send(fill(17'h00001), 3'd4);
    wait_drain();

    // Per-beat configuration change
    cfg_list = '{3'd4, 3'd0, 3'd2};
    step();
    foreach (cfg_list[i]) send(fill(17'd2), cfg_list[i]);
    wait_drain();

    // Reset with two beats in flight
    step();
    n0 = n_out_a;
    if_a.sum_ready = 1'b0;
    send(fill(17'd7), 3'd4);
    send(fill(17'd9), 3'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(if_a.sum_valid), 64'd0);
    check("midrst_pd", 64'(if_a.sum_pd), 64'd0);
    check("midrst_sat", 64'(if_a.sum_sat), 64'd0);
    check("midrst_b_valid", 64'(if_b.sum_valid), 64'd0);
    q_a.delete();
    q_b.delete();
    step();
    if_a.sum_ready = 1'b1;
    send(ramp(), 3'd2);
    wait_drain();
    check("midrst_beat_count", 64'(n_out_a - n0), 64'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
